// File: rtl/cgate_hs_sequencer.sv
// Four-phase return-to-zero handshake master for the C-element pipeline.
// Sends num_tokens tokens, measures rising-phase latency, aborts on phase stall.
module cgate_hs_sequencer #(
  parameter logic [7:0] TIMEOUT = 8'd200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] num_tokens,
  input  logic       ack_in,
  output logic       req_out,
  output logic       busy,
  output logic       done,
  output logic [1:0] err,
  output logic [7:0] token_count,
  output logic [7:0] last_latency
);

  typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;

  state_t     state, state_n;
  logic       ack_m, ack_s;
  logic [7:0] pc, pc_n, pc_inc;
  logic [7:0] remaining, remaining_n;
  logic [7:0] token_count_n, last_latency_n;
  logic [1:0] err_n;
  logic       done_n;

  assign pc_inc = (pc == 8'hff) ? pc : pc + 8'd1;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ack_m        <= 1'b0;
      ack_s        <= 1'b0;
      pc           <= 8'd0;
      remaining    <= 8'd0;
      token_count  <= 8'd0;
      last_latency <= 8'd0;
      err          <= 2'b00;
      done         <= 1'b0;
      req_out      <= 1'b0;
    end else begin
      state        <= state_n;
      ack_m        <= ack_in;
      ack_s        <= ack_m;
      pc           <= pc_n;
      remaining    <= remaining_n;
      token_count  <= token_count_n;
      last_latency <= last_latency_n;
      err          <= err_n;
      done         <= done_n;
      req_out      <= (state_n == REQ_HI);
    end
  end

  always_comb begin
    state_n        = state;
    pc_n           = 8'd0;
    remaining_n    = remaining;
    token_count_n  = token_count;
    last_latency_n = last_latency;
    err_n          = err;
    done_n         = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          remaining_n   = num_tokens;
          token_count_n = 8'd0;
          err_n         = 2'b00;
          if (ack_s) begin
            err_n  = 2'b11;
            done_n = 1'b1;
          end else if (num_tokens == 8'd0) begin
            done_n = 1'b1;
          end else begin
            state_n = REQ_HI;
          end
        end
      end
      REQ_HI: begin
        pc_n = pc_inc;
        if (ack_s) begin
          last_latency_n = pc;
          pc_n           = 8'd0;
          state_n        = REQ_LO;
        end else if (pc == TIMEOUT) begin
          err_n   = 2'b01;
          done_n  = 1'b1;
          pc_n    = 8'd0;
          state_n = IDLE;
        end
      end
      REQ_LO: begin
        pc_n = pc_inc;
        if (!ack_s) begin
          token_count_n = token_count + 8'd1;
          remaining_n   = remaining - 8'd1;
          pc_n          = 8'd0;
          // remaining is decremented on this edge, so 1 means the last token
          if (remaining == 8'd1) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = REQ_HI;
          end
        end else if (pc == TIMEOUT) begin
          err_n   = 2'b10;
          done_n  = 1'b1;
          pc_n    = 8'd0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cgate_hs_sequencer.sv
// Scoreboard bench: stimulus pushes expected end-of-sequence results,
// a monitor pops and compares them on every done pulse.
module tb_cgate_hs_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] num_tokens;
  logic       ack_in;
  logic       req_out, busy, done;
  logic [1:0] err;
  logic [7:0] token_count, last_latency;

  // ack source: 0 loopback, 1 delayed by 7, 2 tied low, 3 loopback then stuck high
  int         mode;
  logic [6:0] dly;
  logic       hold;

  typedef struct {
    int tc;
    int er;
    int lat;
    int bc;
    int hr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_seen = 0;
  int   busy_cnt = 0, hi_run = 0, hi_max = 0;

  always #5 clk = ~clk;

  cgate_hs_sequencer #(.TIMEOUT(8'd10)) dut (
    .clk(clk), .rst(rst), .start(start), .num_tokens(num_tokens),
    .ack_in(ack_in), .req_out(req_out), .busy(busy), .done(done),
    .err(err), .token_count(token_count), .last_latency(last_latency)
  );

  always @(posedge clk) begin
    dly <= {dly[5:0], req_out};
    if (mode != 3) hold <= 1'b0;
    else if (req_out) hold <= 1'b1;
  end

  assign ack_in = (mode == 0) ? req_out :
                  (mode == 1) ? dly[6]  :
                  (mode == 2) ? 1'b0    : (req_out | hold);

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("token_count", token_count, e.tc);
        check("err", err, e.er);
        check("last_latency", last_latency, e.lat);
        check("busy_cycles", busy_cnt, e.bc);
        check("req_high_run", hi_max, e.hr);
      end
      busy_cnt = 0; hi_run = 0; hi_max = 0;
    end else if (!busy) begin
      busy_cnt = 0; hi_run = 0; hi_max = 0;
    end else begin
      busy_cnt++;
      if (req_out) begin
        hi_run++;
        if (hi_run > hi_max) hi_max = hi_run;
      end else begin
        hi_run = 0;
      end
    end
  end

  task automatic run(input int n, input int m, input exp_t e, input bit imm, input bit mid_start);
    int prev;
    bit seen;
    mode = m;
    exp_q.push_back(e);
    prev = done_seen;
    @(posedge clk); #1;
    start = 1'b1;
    num_tokens = 8'(n);
    @(posedge clk); #1;
    start = 1'b0;
    if (imm) check("done_immediate", done, 1);
    else     check("busy_after_start", busy, 1);
    if (mid_start) begin
      repeat (8) @(posedge clk);
      #1 start = 1'b1; num_tokens = 8'd1;
      @(posedge clk); #1 start = 1'b0;
    end
    seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(posedge clk);
      if (done_seen != prev) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 0, 1);
    repeat (12) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_tokens = 8'd0; mode = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_req_out", req_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_token_count", token_count, 0);
    check("rst_last_latency", last_latency, 0);
    repeat (4) @(posedge clk);

    run(5, 0, '{tc:5, er:0, lat:2, bc:30, hr:3}, 1'b0, 1'b0);
    run(1, 1, '{tc:1, er:0, lat:9, bc:20, hr:10}, 1'b0, 1'b0);
    run(3, 2, '{tc:0, er:1, lat:9, bc:11, hr:11}, 1'b0, 1'b0);
    run(2, 3, '{tc:0, er:2, lat:2, bc:14, hr:3}, 1'b0, 1'b0);
    run(5, 3, '{tc:0, er:3, lat:2, bc:0, hr:0}, 1'b1, 1'b0);
    mode = 0;
    repeat (6) @(posedge clk);
    run(0, 0, '{tc:0, er:0, lat:2, bc:0, hr:0}, 1'b1, 1'b0);
    run(4, 0, '{tc:4, er:0, lat:2, bc:24, hr:3}, 1'b0, 1'b1);

    // long run interrupted by reset; no done is expected for it
    @(posedge clk); #1 start = 1'b1; num_tokens = 8'd200;
    @(posedge clk); #1 start = 1'b0;
    repeat (60) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midrst_req_out", req_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err, 0);
    check("midrst_token_count", token_count, 0);
    check("midrst_last_latency", last_latency, 0);
    repeat (6) @(posedge clk);
    run(2, 0, '{tc:2, er:0, lat:2, bc:12, hr:3}, 1'b0, 1'b0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cgate_hs_sequencer.md
# cgate_hs_sequencer

Synchronous four-phase (return-to-zero) handshake master that sequences tokens through the asynchronous Muller C-element pipeline in the cgates design. It drives `req_out` into the pipeline head and watches the pipeline's `ack_in` through a synchronizer. It counts completed tokens, records the per-token request-to-acknowledge latency in clock cycles, and aborts with an error code when a handshake phase stalls. It sits between the tile's `ui_in`/`uo_out` pins and the C-element ring, so the pipeline can be exercised and characterised from the bench or on silicon.

## Interface
- `TIMEOUT`, default 8'd200: maximum cycles spent waiting in one handshake phase before abort; range 1..255.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: level-sampled; accepted only in IDLE.
- `num_tokens` input 8: tokens to send; sampled on the accepted start.
- `ack_in` input 1: acknowledge from the C-element pipeline; asynchronous to `clk`.
- `req_out` output 1: registered request to the pipeline.
- `busy` output 1: high while a sequence is in progress.
- `done` output 1: one-cycle pulse at the end of a sequence (normal or aborted).
- `err` output 2: 00 none; 01 timeout waiting ack high; 10 timeout waiting ack low; 11 ack already high at start. Sticky until the next accepted start.
- `token_count` output 8: completed tokens in the current or last sequence.
- `last_latency` output 8: saturating cycle count for the most recent rising phase.

## Operation
- `ack_in` passes through a 2-flop synchronizer; `ack_s` is the second flop. The FSM uses only `ack_s`.
- **IDLE**, on `start`:
  - Latch `num_tokens` as `remaining`; clear `token_count` and `err`.
  - If `ack_s`=1: `err`=11, pulse `done`, stay IDLE.
  - Else if `num_tokens`=0: pulse `done`, stay IDLE.
  - Else: go to REQ_HI.
- **REQ_HI**:
  - `req_out`=1, phase counter `pc` is 0 on entry and increments each cycle, saturating at 255.
  - `ack_s`=1: `last_latency`<=`pc`, go to REQ_LO.
  - Else `pc`==`TIMEOUT`: `err`=01, go to IDLE with `done` pulse.
- **REQ_LO**:
  - `req_out`=0, `pc` restarts at 0.
  - `ack_s`=0: `token_count`+=1 (wraps at 8 bits), `remaining`-=1.
    - If `remaining` becomes 0: go to IDLE with `done` pulse.
    - Else: go to REQ_HI.
  - Else `pc`==`TIMEOUT`: `err`=10, go to IDLE with `done` pulse.
- `req_out` is 0 in every state except REQ_HI.
- `busy`=1 exactly in REQ_HI and REQ_LO.
- `start` while `busy` is ignored, with no effect on the running sequence.
- `rst` mid-sequence: next edge forces IDLE. `req_out`, `busy`, `done`, `err`, `token_count`, `last_latency`, `pc`, `remaining` and both synchronizer flops all become 0. The pipeline is left to drain by itself.

## Timing
- Reset values: every output is 0; state is IDLE.
- Start accepted at edge t: `req_out`=1 and `busy`=1 from edge t+1.
- Synchronizer latency is 2 edges. The FSM reacts at the third edge after `ack_in` changes.
- Zero-delay loopback (`ack_in`=`req_out`): each token takes 6 cycles (3 with `req_out` high, 3 low), and `last_latency`=2.
- An external pipeline delay of d cycles adds about d to `last_latency` and to the high phase.
- `done` is asserted in the first IDLE cycle, the same edge on which `busy` falls. `token_count` and `err` are already final in that cycle.
- Timeout fires on the edge after the cycle in which `pc`==`TIMEOUT` with no ack. Abort is TIMEOUT+1 cycles after phase entry; `req_out` drops on that same edge.
- Back-to-back: `start` held high in the `done` cycle is accepted on the next edge.

## Test plan
- Loopback `ack_in`=`req_out`, `num_tokens`=5, pulse `start` -> 5 req pulses spaced 6 cycles; `done` 30 cycles after `busy` rises; `token_count`=5, `last_latency`=2, `err`=00.
- `ack_in` = `req_out` delayed by 7 cycles, `num_tokens`=1 -> `last_latency`=9, `token_count`=1, `done` once.
- `ack_in` tied 0, `TIMEOUT`=10, `num_tokens`=3 -> `req_out` high 11 cycles then 0; `err`=01, `token_count`=0, `done` pulse.
- Loopback until first ack, then force `ack_in`=1 -> `err`=10 after TIMEOUT+1 cycles in REQ_LO; `token_count`=0. A new `start` with `ack_in` still 1 -> immediate `done` with `err`=11, `req_out` stays 0.
- `num_tokens`=0 plus `start` -> `done` pulse the next cycle, `busy` never high, `req_out` never high.
- Loopback `num_tokens`=200, assert `rst` for 1 cycle mid-sequence -> all outputs 0 next cycle. A `start` during `busy` before the reset leaves `remaining` unchanged.
